// File: rtl/systolic_matmul.sv
// ---------------------------------------------------------------------------
// systolic_matmul : output-stationary M x P systolic array computing C = A x B
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module systolic_matmul #(
  parameter int N      = 16,
  parameter int M      = 3,
  parameter int K      = 3,
  parameter int P      = 3,
  parameter int SIGNED = 0,
  localparam int ACCW  = 2*N + $clog2(K+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid,
  input  logic [M-1:0][K-1:0][N-1:0]    a,
  input  logic [K-1:0][P-1:0][N-1:0]    b,
  output logic                          ready,
  output logic                          done,
  output logic [M-1:0][P-1:0][ACCW-1:0] c
);

  localparam int T  = K + M + P - 2;
  localparam int TW = $clog2(T + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [TW-1:0] t;
  logic        accept;
  logic        last;

  // One shift register per row/column: the low P (or M) slots are the
  // inter-PE pipeline, the upper slots hold the pre-skewed operands.
  logic [M-1:0][T-1:0][N-1:0] a_sh;
  logic [P-1:0][T-1:0][N-1:0] b_sh;

  assign accept = valid & ready;
  assign last   = (t == TW'(T - 1));

  function automatic logic [ACCW-1:0] mul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*N-1:0] xe, ye, p;
    logic           xs, ys;
    xs = (SIGNED != 0) && x[N-1];
    ys = (SIGNED != 0) && y[N-1];
    xe = {{N{xs}}, x};
    ye = {{N{ys}}, y};
    p  = xe * ye;
    return {{(ACCW-2*N){(SIGNED != 0) && p[2*N-1]}}, p};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (valid) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh <= '0;
      b_sh <= '0;
      t    <= '0;
    end else if (accept) begin
      t    <= '0;
      a_sh <= '0;
      b_sh <= '0;
      for (int i = 0; i < M; i++)
        for (int k = 0; k < K; k++)
          a_sh[i][P-1+k+i] <= a[i][k];
      for (int j = 0; j < P; j++)
        for (int k = 0; k < K; k++)
          b_sh[j][M-1+k+j] <= b[k][j];
    end else if (state == RUN) begin
      t <= t + 1'b1;
      for (int i = 0; i < M; i++) a_sh[i] <= a_sh[i] >> N;
      for (int j = 0; j < P; j++) b_sh[j] <= b_sh[j] >> N;
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < P; j++) begin : g_col
      logic [ACCW-1:0] acc;
      logic            active;

      // k = t-i-j in [0, K); negative values wrap to large unsigned numbers
      assign active  = (32'(t) - 32'(i + j)) < 32'(K);
      assign c[i][j] = acc;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          acc <= '0;
        else if (accept)
          acc <= '0;
        else if (state == RUN && active)
          acc <= acc + mul(a_sh[i][P-1-j], b_sh[j][M-1-i]);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/systolic_matmul.md
SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

Interface
REQ-001 Parameter N, default 16: operand width in bits.
REQ-002 Parameter M, default 3: rows of A and C.
REQ-003 Parameter K, default 3: columns of A and rows of B (inner dimension), K >= 1.
REQ-004 Parameter P, default 3: columns of B and C.
REQ-005 Parameter SIGNED, default 0: 1 = two's-complement operands, 0 = unsigned.
REQ-006 Local ACCW = 2*N + $clog2(K+1): accumulator and result width.
REQ-007 clk  input  1  sole clock; all state updates on posedge.
REQ-008 rst  input  1  reset, asynchronous, active-high.
REQ-009 valid  input  1  request to start a multiply with current a, b.
REQ-010 a  input  [M][K][N]  matrix A, a[i][k].
REQ-011 b  input  [K][P][N]  matrix B, b[k][j].
REQ-012 ready  output  1  high when idle and able to accept valid.
REQ-013 done  output  1  one-cycle pulse: c holds a fresh result.
REQ-014 c  output  [M][P][ACCW]  result C = A x B, c[i][j].

Function
REQ-015 FSM states IDLE, RUN, DONE; ready = 1 only in IDLE.
REQ-016 Accept = valid & ready at a posedge; a and b are captured into internal registers on that edge, all M*P accumulators cleared, skew counter t set to 0, state -> RUN.
REQ-017 valid while not ready is ignored; a/b changes after the accept edge have no effect on the result.
REQ-018 Array is M x P PEs; at each RUN edge PE(i,j) adds a[i][k]*b[k][j] to its accumulator only when k = t-i-j satisfies 0 <= k < K, otherwise holds.
REQ-019 Operand skew is realised by row/column shift registers (A flows right along rows, B flows down columns); direct indexing of the captured matrix by PEs is not permitted.
REQ-020 RUN lasts exactly T = K+M+P-2 edges (t = 0..T-1), then state -> DONE.
REQ-021 In DONE, done = 1 for exactly one cycle, c equals the accumulators; next edge -> IDLE.
REQ-022 Latency: done is high in the cycle following the (T+1)th posedge after the accept edge (M=K=P=3: 8 edges).
REQ-023 Products are full 2N-bit, sign- or zero-extended per SIGNED to ACCW; accumulation never overflows; no saturation or truncation.
REQ-024 c holds its value from DONE until the next accept edge clears the accumulators; c is not guaranteed stable during RUN.
REQ-025 A new accept is possible in the cycle after DONE (back-to-back throughput 1 per T+2 cycles).
REQ-026 K=1, M=1 or P=1 degenerate shapes are legal and follow the same timing formula.

Reset
REQ-027 rst high forces, immediately and independent of clk: state IDLE, ready 1, done 0, c all zeros, accumulators, shift registers and t zero.
REQ-028 rst during RUN or DONE aborts the operation; no done pulse is produced for it; the first post-reset accept behaves as from power-up.
REQ-029 valid sampled in the same cycle rst is high is ignored.

Verification
REQ-030 Defaults, all a = 11, all b = 12, valid 1 cycle -> done exactly 8 edges later, every c[i][j] = 396, ready low during RUN/DONE.
REQ-031 A = identity, B = {1..9} row-major -> c equals B; then A = B = {1..9} back-to-back next cycle after done -> c = {30,36,42; 66,81,96; 102,126,150}.
REQ-032 SIGNED=1, N=8, all a = -128, all b = -128 -> every c = 49152; a = -1, b = 127 -> every c = -381 sign-correct in ACCW bits.
REQ-033 valid pulsed and a, b changed at random every cycle during RUN -> result and done timing unchanged from the accepted operands.
REQ-034 rst asserted mid-RUN between edges -> c, done clear asynchronously, no done pulse; a following accept yields correct result with standard latency.
REQ-035 Non-square M=2, K=4, P=5 against a software reference over 100 random unsigned matrices at max-value corners (all 0xFFFF) -> exact match, done at T+1 = 10 edges.
